// File: rtl/up_down_counter_param.sv
// up_down_counter_param: single-clock modulo-N up/down counter with load, wrap/saturate and event pulses
// Ports:
//   clk       rising-edge system clock
//   resetb    asynchronous active-low reset
//   en        count enable, one step per clock
//   up        direction, 1 = increment, 0 = decrement
//   load      synchronous load strobe, wins over en
//   load_val  value to load, clamped to max_val
//   max_val   inclusive upper limit, range is 0..max_val
//   sat       1 = saturate at limits, 0 = wrap
//   count     registered counter value
//   ovf       registered pulse, up-step taken at max_val
//   unf       registered pulse, down-step taken at 0
//   at_max    combinational count == max_val
//   at_zero   combinational count == 0
module up_down_counter_param #(
    parameter int WIDTH = 4,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             resetb,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] max_val,
    input  logic             sat,
    output logic [WIDTH-1:0] count,
    output logic             ovf,
    output logic             unf,
    output logic             at_max,
    output logic             at_zero
);
    logic [WIDTH-1:0] count_n;
    logic oor, step, ovf_n, unf_n;
    // a lowered limit can leave count above max_val; any step pulls it back to the limit
    assign oor = count > max_val;
    assign at_max = count == max_val;
    assign at_zero = count == '0;
    assign step = en && !load && !oor;
    assign ovf_n = step && up && at_max;
    assign unf_n = step && !up && at_zero;
    always_comb begin
        count_n = count;
        if (load)
            count_n = load_val > max_val ? max_val : load_val;
        else if (en && oor)
            count_n = max_val;
        else if (en)
            count_n = up ? (at_max ? (sat ? count : '0) : count + WIDTH'(1))
                         : (at_zero ? (sat ? count : max_val) : count - WIDTH'(1));
    end
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            count <= RST_VAL;
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            count <= count_n;
            ovf <= ovf_n;
            unf <= unf_n;
        end
    end
endmodule

// File: doc/up_down_counter_param.md
Name: up_down_counter_param

Overview:
- Parametrised synchronous up/down counter. It is the next generation of the team's ripple T-flip-flop up/down counter with load.
- Width is generic. Upper limit is run-time programmable (modulo-N). Wrap or saturate mode is selectable.
- Provides synchronous load, count enable, and registered overflow/underflow event pulses.
- Used as a general-purpose timer/index counter. All state bits switch on the single clock edge, with no rippled clocks.

Parameters:
- WIDTH, 4, counter width in bits (>= 2).
- RST_VAL, 0, value loaded into count on reset (must be <= 2^WIDTH-1).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- resetb  input  1  asynchronous active-low reset.
- en  input  1  count enable; one step per clock while high.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous load strobe.
- load_val  input  WIDTH  value to load.
- max_val  input  WIDTH  inclusive upper limit; count range is 0..max_val.
- sat  input  1  1 = saturate at limits, 0 = wrap around.
- count  output  WIDTH  current counter value (registered).
- ovf  output  1  one-cycle pulse, registered: up-step taken at max_val.
- unf  output  1  one-cycle pulse, registered: down-step taken at 0.
- at_max  output  1  combinational: count == max_val.
- at_zero  output  1  combinational: count == 0.

Behaviour:
- Reset (resetb low, asynchronous assert; effective from next edge after release):
  - count = RST_VAL; ovf = 0; unf = 0.
- Priority per rising edge: reset > load > en > hold.
- ovf/unf default to 0 every cycle. They are high for exactly one cycle after the causing edge and are never both high.
- Load:
  - count <= min(load_val, max_val).
  - ovf = unf = 0, regardless of en/up.
- Enabled up-step, count < max_val: count <= count+1.
- Enabled up-step, count == max_val:
  - sat=1: count holds, ovf <= 1.
  - sat=0: count <= 0, ovf <= 1.
- Enabled down-step, count > 0 and count <= max_val: count <= count-1.
- Enabled down-step, count == 0:
  - sat=1: count holds, unf <= 1.
  - sat=0: count <= max_val, unf <= 1.
- Out-of-range (count > max_val, e.g. max_val lowered at run time):
  - Any enabled step forces count <= max_val, with no ovf/unf.
  - Holding (en=0) leaves count unchanged.
- max_val = 0: count stays 0.
  - Up-step: ovf each enabled cycle.
  - Down-step: unf each enabled cycle.
  - Mode (sat/wrap) has no visible difference.
- max_val = 2^WIDTH-1: full binary range. Arithmetic is WIDTH bits with no carry-out port; wrap is explicit via the limit compare.
- en=0 and load=0: count holds, ovf = unf = 0.
- up and sat are sampled only on edges where en=1 and load=0. They may change any cycle.
- at_max/at_zero follow count and max_val combinationally, with no latency.
- Latency: count reflects the load or step one clock after the sampling edge. ovf/unf assert in the same cycle count updates.

Test Plan (WIDTH=4, RST_VAL=0 unless stated):
- Reset/hold: assert resetb=0 mid-count at count=7 -> count=0, ovf=unf=0 immediately, without waiting for a clock. After release with en=0 for 5 clocks -> count stays 0, at_zero=1.
- Wrap up: max_val=9, sat=0, up=1, en=1 from 0 for 12 clocks -> count 1..9,0,1,2. ovf high only in the cycle count becomes 0. at_max high while count=9.
- Saturate down: max_val=9, sat=1, load_val=2 loaded, then up=0, en=1 for 5 clocks -> count 1,0,0,0,0. unf high in each cycle where the step was taken at 0 (3 pulses).
- Load priority/clamp: load=1, load_val=13, max_val=9, en=1, up=1 in same cycle -> count=9, ovf=0. Next clock, en=1, sat=0 -> count=0, ovf=1.
- Down wrap with limit change: max_val=15, count=12. Set max_val=5, en=1, up=0 -> count=5, no unf. Continue 6 clocks, sat=0 -> 4,3,2,1,0,5 with unf on the final step.
- Degenerate limit: max_val=0, en=1, up=1, sat toggling each cycle for 4 clocks -> count=0 throughout, ovf=1 on every cycle, unf=0.
